led_accum_adder: RTL and testbench

LED_ACCUM_ADDER -- requirements
Module: led_accum_adder

---
 rtl/led_adder_pkg.sv | 15 +
 rtl/switch_debounce.sv | 51 +++++
 rtl/led_accum_adder.sv | 137 +++++++++++++
 tb/tb_led_accum_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_adder_pkg.sv
// led_adder_pkg
// Shared definitions for the LED accumulator adder:
//   state_t                 - control FSM states (IDLE, COMPUTE, HOLD)
//   DEFAULT_DEBOUNCE_CYCLES - default input stable time (10 ms at 25 MHz)
package led_adder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce
// One-bit 2-flop synchronizer followed by a counter-based debouncer.
// The debounced output follows the synchronized input only after the two
// have differed for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (clears flops and counter)
//   din   - raw asynchronous input
//   dout  - debounced, clk-synchronous output
module switch_debounce
  import led_adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
    end else begin
      // synchronizer stage
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // debounce stage: any clock where the input agrees with the output
      // restarts the stability count
      if (sync_p1 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        dout <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_accum_adder.sv
// led_accum_adder
// Switch-driven adder/accumulator shown on LEDs. Each press of btn_go
// (debounced) commits one operation: mode 0 loads A+B, mode 1 adds A into
// the accumulator. Overflow in mode 1 sets a sticky flag cleared only by a
// mode-0 commit or reset.
// Build option: define LED_ACCUM_ADDER_SAT_EN to saturate the accumulator
// to all ones on a mode-1 overflow instead of wrapping.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   sw_a    - operand A switches (async)
//   sw_b    - operand B switches (async)
//   btn_go  - commit button, active-high (async)
//   mode    - 0 = load A+B, 1 = accumulate ACC+A; sampled at commit
//   led     - accumulator value, WIDTH+1 bits
//   ovf     - sticky overflow flag
//   busy    - high while the FSM is in COMPUTE or HOLD
module led_accum_adder
  import led_adder_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  input  logic             btn_go,
  input  logic             mode,
  output logic [WIDTH:0]   led,
  output logic             ovf,
  output logic             busy
);

`ifdef LED_ACCUM_ADDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int ACC_W = WIDTH + 1;
  localparam int SUM_W = WIDTH + 2;

  logic [WIDTH-1:0] a_db;
  logic [WIDTH-1:0] b_db;
  logic             go_db;
  logic             go_db_q;
  logic [1:0]       mode_sync;
  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   load_sum;
  logic [WIDTH+1:0] accum_sum;

  // Result of a mode-1 commit: wrap, or clamp to all ones when saturating.
  function automatic logic [WIDTH:0] accum_result(input logic [WIDTH+1:0] sum);
    if (SAT_EN && sum[WIDTH+1]) begin
      return '1;
    end
    return sum[WIDTH:0];
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_sw
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sw_a[i]),
      .dout (a_db[i])
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sw_b[i]),
      .dout (b_db[i])
    );
  end

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_go (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_go),
    .dout (go_db)
  );

  // A+B fits in WIDTH+1 bits; ACC+A needs one extra bit to expose the carry.
  assign load_sum  = ACC_W'(a_db) + ACC_W'(b_db);
  assign accum_sum = {1'b0, acc} + SUM_W'(a_db);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      go_db_q   <= 1'b0;
      mode_sync <= 2'b00;
      acc       <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      go_db_q   <= go_db;
      // mode is a plain switch; only metastability protection is needed
      mode_sync <= {mode_sync[0], mode};
      case (state)
        IDLE: begin
          if (go_db && !go_db_q) begin
            state <= COMPUTE;
            busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          if (!mode_sync[1]) begin
            acc <= load_sum;
            ovf <= 1'b0;
          end else begin
            acc <= accum_result(accum_sum);
            if (accum_sum[WIDTH+1]) begin
              ovf <= 1'b1;
            end
          end
          state <= HOLD;
          busy  <= 1'b1;
        end
        HOLD: begin
          // stay here until the button is released so a long press commits once
          if (!go_db) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led = acc;

endmodule

// File: tb/tb_led_accum_adder.sv
// tb_led_accum_adder
// Directed-vector bench for led_accum_adder (WIDTH = 2, DEBOUNCE_CYCLES = 4).
// Each commit pushes its expected led/ovf into a queue; a monitor pops and
// compares one clock after busy rises, when the new result is on led.
module tb_led_accum_adder;

  localparam int WIDTH = 2;
  localparam int DEB   = 4;

  typedef struct {
    logic [WIDTH:0] led;
    logic           ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw_a;
  logic [WIDTH-1:0] sw_b;
  logic             btn_go;
  logic             mode;
  logic [WIDTH:0]   led;
  logic             ovf;
  logic             busy;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  led_accum_adder #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_a  (sw_a),
    .sw_b  (sw_b),
    .btn_go(btn_go),
    .mode  (mode),
    .led   (led),
    .ovf   (ovf),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [WIDTH:0] act,
                           input logic [WIDTH:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic busy_d;
    logic pend;
    exp_t e;
    busy_d = 1'b0;
    pend   = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got led %0d ovf %0d expected no commit", led, ovf);
        end else begin
          e = exp_q.pop_front();
          check_val("commit_led", led, e.led);
          check_val("commit_ovf", {2'b00, ovf}, {2'b00, e.ovf});
        end
      end
      if (busy && !busy_d) pend = 1'b1;
      busy_d = busy;
    end
  end

  task automatic commit(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic m, input logic [WIDTH:0] eled, input logic eovf);
    sw_a = a;
    sw_b = b;
    mode = m;
    repeat (10) @(negedge clk);
    exp_q.push_back('{led: eled, ovf: eovf});
    btn_go = 1'b1;
    repeat (20) @(negedge clk);
    btn_go = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [WIDTH:0] held;
    rst_n  = 1'b0;
    sw_a   = '0;
    sw_b   = '0;
    btn_go = 1'b0;
    mode   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_led", led, 3'd0);
    check_val("reset_ovf", {2'b00, ovf}, 3'd0);
    check_val("reset_busy", {2'b00, busy}, 3'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load 3 + 2, with busy observed during and after the press
    sw_a = 2'd3;
    sw_b = 2'd2;
    mode = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back('{led: 3'd5, ovf: 1'b0});
    btn_go = 1'b1;
    repeat (20) @(negedge clk);
    check_val("busy_in_hold", {2'b00, busy}, 3'd1);
    btn_go = 1'b0;
    repeat (12) @(negedge clk);
    check_val("busy_after_release", {2'b00, busy}, 3'd0);

    // Build ACC = 7, then accumulate 3 to overflow, then clear with 0+0
    commit(2'd3, 2'd3, 1'b0, 3'd6, 1'b0);
    commit(2'd1, 2'd0, 1'b1, 3'd7, 1'b0);
`ifdef LED_ACCUM_ADDER_SAT_EN
    commit(2'd3, 2'd0, 1'b1, 3'd7, 1'b1);
`else
    commit(2'd3, 2'd0, 1'b1, 3'd2, 1'b1);
`endif
    commit(2'd0, 2'd0, 1'b0, 3'd0, 1'b0);

    // ACC = 6 plus 3 overflows; a following +0 keeps ovf sticky
    commit(2'd3, 2'd3, 1'b0, 3'd6, 1'b0);
`ifdef LED_ACCUM_ADDER_SAT_EN
    commit(2'd3, 2'd0, 1'b1, 3'd7, 1'b1);
    commit(2'd0, 2'd0, 1'b1, 3'd7, 1'b1);
    held = 3'd7;
`else
    commit(2'd3, 2'd0, 1'b1, 3'd1, 1'b1);
    commit(2'd0, 2'd0, 1'b1, 3'd1, 1'b1);
    held = 3'd1;
`endif

    // Operand and mode changes without a press leave the result alone
    sw_a = 2'd2;
    sw_b = 2'd1;
    mode = 1'b0;
    repeat (20) @(negedge clk);
    check_val("idle_led_hold", led, held);
    check_val("idle_ovf_hold", {2'b00, ovf}, 3'd1);

    // Short bounces must not commit
    sw_a = 2'd1;
    sw_b = 2'd2;
    for (int len = 1; len <= 3; len++) begin
      btn_go = 1'b1;
      repeat (len) @(negedge clk);
      btn_go = 1'b0;
      repeat (10) @(negedge clk);
    end
    check_val("bounce_led", led, held);
    check_val("bounce_busy", {2'b00, busy}, 3'd0);
    commit(2'd1, 2'd2, 1'b0, 3'd3, 1'b0);

    // Reset while held in HOLD, then one commit after the debounced re-rise
    sw_a = 2'd2;
    sw_b = 2'd2;
    mode = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back('{led: 3'd4, ovf: 1'b0});
    btn_go = 1'b1;
    repeat (15) @(negedge clk);
    check_val("busy_before_reset", {2'b00, busy}, 3'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midreset_led", led, 3'd0);
    check_val("midreset_ovf", {2'b00, ovf}, 3'd0);
    check_val("midreset_busy", {2'b00, busy}, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{led: 3'd4, ovf: 1'b0});
    repeat (20) @(negedge clk);
    btn_go = 1'b0;
    repeat (12) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_commits: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
